// File: rtl/fetch_sequencer.sv
// Program counter and run-control sequencer for the instruction memory.
// Owns the instruction memory address, retires one instruction per valid
// cycle, applies taken branches and implements run/step/stop, breakpoint
// and end-of-program halt control.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0000,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [63:0] HALT_ADDR = 64'h006C,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic             bkpt_en,
  input  logic [63:0]      bkpt_addr,
  input  logic             branch_taken,
  input  logic [63:0]      branch_target,
  output logic [63:0]      imem_addr,
  input  logic [31:0]      instr_in,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t           st_q;
  logic [63:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bkpt_skip_q;

  logic             at_halt_addr;
  logic             bkpt_hit;
  logic             hc;
  logic             active;
  logic             retire;
  logic [63:0]      pc_next;

  // Address LSBs of breakpoint and branch target are don't-care by design.
  logic             unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bkpt_addr[1:0], branch_target[1:0]};

  assign at_halt_addr = (pc_q == HALT_ADDR);
  assign bkpt_hit     = bkpt_en && (pc_q[63:2] == bkpt_addr[63:2]) && !bkpt_skip_q;
  assign hc           = at_halt_addr || bkpt_hit;
  assign active       = (st_q == RUN) || (st_q == STEP);
  assign retire       = instr_valid && !stop;
  assign pc_next      = branch_taken ? {branch_target[63:2], 2'b00}
                                     : pc_q + 64'(PC_STEP);

  // Outputs derived from the registered state and current pc.
  always_comb begin
    imem_addr     = pc_q;
    instr_valid   = active && !hc;
    instr_out     = instr_valid ? instr_in : '0;
    state         = st_q;
    halted        = (st_q == HALT);
    retired_count = cnt_q;
  end

  // Run-control FSM, pc, retire counter and breakpoint-skip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      bkpt_skip_q <= 1'b0;
    end else begin
      if (retire) begin
        pc_q        <= pc_next;
        bkpt_skip_q <= 1'b0;
        if (cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
      end
      case (st_q)
        IDLE: begin
          if (start)     st_q <= RUN;
          else if (step) st_q <= STEP;
        end
        RUN: begin
          if (stop)      st_q <= IDLE;
          else if (hc)   st_q <= HALT;
        end
        STEP: begin
          // A blocked step halts; stop or a completed retire returns to IDLE.
          if (!stop && hc) st_q <= HALT;
          else             st_q <= IDLE;
        end
        HALT: begin
          // Only a breakpoint halt can be resumed; the end address needs reset.
          if (!at_halt_addr) begin
            if (start) begin
              st_q        <= RUN;
              bkpt_skip_q <= 1'b1;
            end else if (step) begin
              st_q        <= STEP;
              bkpt_skip_q <= 1'b1;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized stimulus
// checked every cycle against a behavioural model of the run-control rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, step = 1'b0, stop = 1'b0;
  logic        bkpt_en = 1'b0;
  logic [63:0] bkpt_addr = '0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [31:0] instr_in = '0;

  logic [63:0] imem_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] retired_count;

  // Second instance: pc wrap from the top of the address space and a tiny
  // counter to reach saturation.
  logic [63:0] w_imem_addr;
  logic [31:0] w_instr_out;
  logic        w_instr_valid;
  logic [1:0]  w_state;
  logic        w_halted;
  logic [1:0]  w_retired_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic [63:0] m_pc;
  int          m_st;     // 0 IDLE, 1 RUN, 2 STEP, 3 HALT
  longint      m_cnt;
  bit          m_skip;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .instr_in(instr_in),
    .instr_out(instr_out), .instr_valid(instr_valid), .state(state),
    .halted(halted), .retired_count(retired_count)
  );

  fetch_sequencer #(
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC),
    .CNT_W(2)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(w_imem_addr), .instr_in(instr_in),
    .instr_out(w_instr_out), .instr_valid(w_instr_valid), .state(w_state),
    .halted(w_halted), .retired_count(w_retired_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hc();
    return (m_pc == 64'h6C) ||
           (bkpt_en && (m_pc >> 2) == (bkpt_addr >> 2) && !m_skip);
  endfunction

  function automatic bit m_valid();
    return (m_st == 1 || m_st == 2) && !m_hc();
  endfunction

  function automatic void m_reset();
    m_pc = 64'h0; m_st = 0; m_cnt = 0; m_skip = 0;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  function automatic void m_edge();
    bit v;
    v = m_valid();
    if (v && !stop) begin
      m_pc   = branch_taken ? (branch_target & ~64'h3) : m_pc + 64'd4;
      m_cnt  = (m_cnt == 64'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      m_skip = 0;
      m_st   = (m_st == 2) ? 0 : 1;
    end else if (m_st == 0) begin
      m_st = start ? 1 : (step ? 2 : 0);
    end else if (m_st == 1 || m_st == 2) begin
      // not retiring while active: either stopped or blocked by halt condition
      m_st = stop ? 0 : 3;
    end else if (m_pc != 64'h6C && (start || step)) begin
      m_st   = start ? 1 : 2;
      m_skip = 1;
    end
  endfunction

  task automatic compare_all();
    bit v;
    v = m_valid();
    check("imem_addr", imem_addr, m_pc);
    check("state", 64'(state), 64'(m_st));
    check("halted", 64'(halted), 64'(m_st == 3));
    check("instr_valid", 64'(instr_valid), 64'(v));
    check("instr_out", 64'(instr_out), v ? 64'(instr_in) : 64'h0);
    check("retired_count", 64'(retired_count), m_cnt);
  endtask

  // Called away from edges with inputs already set: check, clock, update model.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
  endtask

  // Mid-cycle asynchronous reset; outputs must clear with no clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_pc", imem_addr, 64'h0);
    check("rst_state", 64'(state), 64'h0);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_instr_out", 64'(instr_out), 64'h0);
    check("rst_count", 64'(retired_count), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; step = 0; stop = 0; bkpt_en = 0; bkpt_addr = '0;
    branch_taken = 0; branch_target = '0;
  endtask

  initial begin
    m_reset();
    instr_in = 32'hDEAD_BEEF;
    @(negedge clk);
    do_reset();

    // Wrap and saturation on the second instance, one step then run.
    check("wrap_rst_pc", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step = 1; tick(); tick(); step = 0;
    check("wrap_pc", w_imem_addr, 64'h0);
    check("wrap_count", 64'(w_retired_count), 64'd1);
    check("wrap_state", 64'(w_state), 64'd0);
    start = 1; for (int i = 0; i < 5; i++) tick(); start = 0;
    check("sat_count", 64'(w_retired_count), 64'd3);
    do_reset();

    // Free run to the end-of-program address.
    start = 1;
    for (int i = 0; i < 32; i++) tick();
    check("run_halt_state", 64'(state), 64'd3);
    check("run_halt_pc", imem_addr, 64'h6C);
    check("run_halt_count", 64'(retired_count), 64'd27);
    check("run_halt_valid", 64'(instr_valid), 64'd0);
    step = 1; tick(); tick(); step = 0;
    check("halt_sticky", 64'(state), 64'd3);
    start = 0;
    do_reset();

    // Single step from IDLE at pc 0x10.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) tick();
    stop = 1; tick(); stop = 0;
    check("stop_pc", imem_addr, 64'h10);
    check("stop_state", 64'(state), 64'd0);
    step = 1; tick(); tick(); step = 0;
    check("step_pc", imem_addr, 64'h14);
    check("step_state", 64'(state), 64'd0);
    check("step_count", 64'(retired_count), 64'd5);
    tick();
    step = 1; tick(); tick(); step = 0;
    check("step2_pc", imem_addr, 64'h18);

    // Branches while running, then a self loop at 0x28.
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    check("stop_start_run", 64'(state), 64'd1);
    while (imem_addr != 64'h28 && n_cmp < 2000) tick();
    branch_taken = 1; branch_target = 64'h1F; tick();
    check("br_pc", imem_addr, 64'h1C);
    branch_target = 64'h28; tick();
    for (int i = 0; i < 3; i++) tick();
    check("loop_pc", imem_addr, 64'h28);
    clear_inputs();
    do_reset();

    // Breakpoint at 0x14, resume past it once.
    bkpt_en = 1; bkpt_addr = 64'h17; start = 1;
    for (int i = 0; i < 7; i++) tick();
    check("bkpt_state", 64'(state), 64'd3);
    check("bkpt_pc", imem_addr, 64'h14);
    check("bkpt_count", 64'(retired_count), 64'd5);
    tick();
    check("bkpt_resume", 64'(state), 64'd1);
    tick();
    check("bkpt_past_pc", imem_addr, 64'h18);
    check("bkpt_past_count", 64'(retired_count), 64'd6);
    clear_inputs();
    do_reset();

    // Stop wins over the end-address halt condition.
    branch_taken = 1; branch_target = 64'h68; start = 1; tick(); tick();
    branch_taken = 0; start = 0; tick();
    check("at_end_pc", imem_addr, 64'h6C);
    stop = 1; tick(); stop = 0;
    check("stop_over_hc", 64'(state), 64'd0);
    clear_inputs();

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        start        = ($urandom_range(0, 7) == 0);
        step         = ($urandom_range(0, 7) == 0);
        stop         = ($urandom_range(0, 15) == 0);
        bkpt_en      = ($urandom_range(0, 2) == 0);
        bkpt_addr    = 64'($urandom_range(0, 'h70));
        branch_taken = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 19) == 0)
          branch_target = {32'hFFFF_FFFF, 32'($urandom_range(32'hFFFF_FFF0, 32'hFFFF_FFFF))};
        else
          branch_target = 64'($urandom_range(0, 'h70));
        instr_in = $urandom;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
